// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor: comparator branch
// encodings and 2-bit saturating counter states.
package branch_predictor_pkg;

  typedef enum logic [2:0] {
    BR_EQ    = 3'b000,
    BR_NE    = 3'b001,
    BR_LT    = 3'b010,
    BR_GE    = 3'b011,
    BR_LTU   = 3'b100,
    BR_GEU   = 3'b101,
    BR_NEVER = 3'b110,
    BR_JUMP  = 3'b111
  } br_type_e;

  localparam logic [1:0] CNT_SNT = 2'd0;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;

  // Conditional branches are every encoding except never-taken and jump.
  function automatic logic is_cond_branch(input br_type_e t);
    return (t != BR_NEVER) && (t != BR_JUMP);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup and update/redirect signal bundle between fetch/execute and the
// branch predictor.
interface branch_predictor_if;

  logic [31:0] lk_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [2:0]  upd_br_type;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  logic        mispredict;
  logic [31:0] redirect_pc;

  modport master (
    output lk_pc, upd_valid, upd_pc, upd_br_type, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc
  );

  modport slave (
    input  lk_pc, upd_valid, upd_pc, upd_br_type, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of one 2-bit saturating branch counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_taken,
  input  logic       i_force_taken,
  input  logic       i_replace,
  output logic [1:0] o_cnt
);

  // Jumps saturate immediately; a freshly replaced entry starts weakly taken.
  always_comb begin
    o_cnt = i_cnt;
    if (i_force_taken) begin
      o_cnt = CNT_ST;
    end else if (i_replace) begin
      o_cnt = CNT_WT;
    end else if (i_taken) begin
      if (i_cnt != CNT_ST) o_cnt = i_cnt + 2'd1;
    end else begin
      if (i_cnt != CNT_SNT) o_cnt = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT of 2-bit counters plus tagged BTB; trains from resolved
// execute-stage outcomes and raises a registered mispredict/redirect.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [1:0]       r_cnt        [ENTRIES];
  logic             r_btb_valid  [ENTRIES];
  logic [TAG_W-1:0] r_btb_tag    [ENTRIES];
  logic [31:0]      r_btb_target [ENTRIES];

  logic             r_mispredict;
  logic [31:0]      r_redirect_pc;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;

  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  br_type_e         w_br_type;
  logic             w_is_cond;
  logic             w_is_jump;
  logic             w_cnt_we;
  logic             w_btb_we;
  logic             w_replace;
  logic [1:0]       w_cnt_next;
  logic             w_mispredict;
  logic [31:0]      w_redirect_pc;

  assign w_lk_idx = bp.lk_pc[IDX_W+1:2];
  assign w_lk_tag = bp.lk_pc[31:IDX_W+2];
  assign w_lk_hit = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);

  // Lookup reads table state directly, so a same-cycle update is not bypassed.
  assign bp.pred_taken  = r_cnt[w_lk_idx][1] & w_lk_hit;
  assign bp.pred_target = bp.pred_taken ? r_btb_target[w_lk_idx] : (bp.lk_pc + 32'd4);

  assign w_upd_idx = bp.upd_pc[IDX_W+1:2];
  assign w_upd_tag = bp.upd_pc[31:IDX_W+2];
  assign w_upd_hit = r_btb_valid[w_upd_idx] && (r_btb_tag[w_upd_idx] == w_upd_tag);
  assign w_br_type = br_type_e'(bp.upd_br_type);
  assign w_is_cond = is_cond_branch(w_br_type);
  assign w_is_jump = (w_br_type == BR_JUMP);

  assign w_cnt_we  = bp.upd_valid & (w_is_cond | w_is_jump);
  assign w_btb_we  = bp.upd_valid & (w_is_jump | (w_is_cond & bp.upd_taken));
  assign w_replace = w_is_cond & bp.upd_taken & ~w_upd_hit;

  sat_counter2 u_sat_counter2 (
    .i_cnt         (r_cnt[w_upd_idx]),
    .i_taken       (bp.upd_taken),
    .i_force_taken (w_is_jump),
    .i_replace     (w_replace),
    .o_cnt         (w_cnt_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_cnt[i]       <= CNT_WNT;
        r_btb_valid[i] <= 1'b0;
      end
    end else begin
      if (w_cnt_we) r_cnt[w_upd_idx] <= w_cnt_next;
      if (w_btb_we) r_btb_valid[w_upd_idx] <= 1'b1;
    end
  end

  // Tag and target need no reset: they are ignored while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (w_btb_we) begin
      r_btb_tag[w_upd_idx]    <= w_upd_tag;
      r_btb_target[w_upd_idx] <= bp.upd_target;
    end
  end

  assign w_mispredict  = bp.upd_valid &
                         ((bp.upd_taken != bp.upd_pred_taken) |
                          (bp.upd_taken & (bp.upd_target != bp.upd_pred_target)));
  assign w_redirect_pc = bp.upd_taken ? bp.upd_target : (bp.upd_pc + 32'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mispredict  <= 1'b0;
      r_redirect_pc <= 32'h0;
    end else begin
      r_mispredict <= w_mispredict;
      if (w_mispredict) r_redirect_pc <= w_redirect_pc;
    end
  end

  assign bp.mispredict  = r_mispredict;
  assign bp.redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=64).
module tb_branch_predictor;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  branch_predictor_if bpIf ();

  branch_predictor #(.ENTRIES(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bpIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one update for a single clock edge, then drop upd_valid.
  task automatic do_update(input logic [31:0] pc, input logic [2:0] brType,
                           input logic taken, input logic [31:0] target,
                           input logic predTaken, input logic [31:0] predTarget);
    bpIf.upd_valid       = 1'b1;
    bpIf.upd_pc          = pc;
    bpIf.upd_br_type     = brType;
    bpIf.upd_taken       = taken;
    bpIf.upd_target      = target;
    bpIf.upd_pred_taken  = predTaken;
    bpIf.upd_pred_target = predTarget;
    @(posedge clk);
    #1;
    bpIf.upd_valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    bpIf.lk_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bpIf.upd_valid = 1'b0;
    bpIf.upd_pc = 32'h0; bpIf.upd_br_type = 3'b000; bpIf.upd_taken = 1'b0;
    bpIf.upd_target = 32'h0; bpIf.upd_pred_taken = 1'b0; bpIf.upd_pred_target = 32'h0;
    lookup(32'h100);
    repeat (2) @(posedge clk);
    #1;
    total++; if (bpIf.pred_taken !== 1'b0) begin bad++; $display("[TB] FAIL reset_pred_taken got=%0b exp=0", bpIf.pred_taken); end
    total++; if (bpIf.pred_target !== 32'h104) begin bad++; $display("[TB] FAIL reset_pred_target got=%h exp=00000104", bpIf.pred_target); end
    total++; if (bpIf.mispredict !== 1'b0) begin bad++; $display("[TB] FAIL reset_mispredict got=%0b exp=0", bpIf.mispredict); end
    total++; if (bpIf.redirect_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_redirect got=%h exp=00000000", bpIf.redirect_pc); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cond_train();
    do_update(32'h100, 3'b000, 1'b1, 32'h80, 1'b0, 32'h104);
    total++; if (bpIf.mispredict !== 1'b1) begin bad++; $display("[TB] FAIL cond_first_mispredict got=%0b exp=1", bpIf.mispredict); end
    total++; if (bpIf.redirect_pc !== 32'h80) begin bad++; $display("[TB] FAIL cond_first_redirect got=%h exp=00000080", bpIf.redirect_pc); end
    lookup(32'h100);
    total++; if (bpIf.pred_taken !== 1'b1) begin bad++; $display("[TB] FAIL cond_trained_taken got=%0b exp=1", bpIf.pred_taken); end
    total++; if (bpIf.pred_target !== 32'h80) begin bad++; $display("[TB] FAIL cond_trained_target got=%h exp=00000080", bpIf.pred_target); end
    // cnt 2 -> 3, correctly predicted
    do_update(32'h100, 3'b000, 1'b1, 32'h80, 1'b1, 32'h80);
    total++; if (bpIf.mispredict !== 1'b0) begin bad++; $display("[TB] FAIL cond_correct_mispredict got=%0b exp=0", bpIf.mispredict); end
    total++; if (bpIf.redirect_pc !== 32'h80) begin bad++; $display("[TB] FAIL cond_redirect_hold got=%h exp=00000080", bpIf.redirect_pc); end
    // cnt 3 -> 2: still predicted taken
    do_update(32'h100, 3'b001, 1'b0, 32'h80, 1'b1, 32'h80);
    total++; if (bpIf.mispredict !== 1'b1) begin bad++; $display("[TB] FAIL nt1_mispredict got=%0b exp=1", bpIf.mispredict); end
    total++; if (bpIf.redirect_pc !== 32'h104) begin bad++; $display("[TB] FAIL nt1_redirect got=%h exp=00000104", bpIf.redirect_pc); end
    total++; if (bpIf.pred_taken !== 1'b1) begin bad++; $display("[TB] FAIL nt1_still_taken got=%0b exp=1", bpIf.pred_taken); end
    // cnt 2 -> 1, back-to-back mispredict pulse
    do_update(32'h100, 3'b001, 1'b0, 32'h80, 1'b1, 32'h80);
    total++; if (bpIf.mispredict !== 1'b1) begin bad++; $display("[TB] FAIL nt2_back_to_back got=%0b exp=1", bpIf.mispredict); end
    total++; if (bpIf.pred_taken !== 1'b0) begin bad++; $display("[TB] FAIL nt2_not_taken got=%0b exp=0", bpIf.pred_taken); end
    total++; if (bpIf.pred_target !== 32'h104) begin bad++; $display("[TB] FAIL nt2_target got=%h exp=00000104", bpIf.pred_target); end
    @(posedge clk);
    #1;
    total++; if (bpIf.mispredict !== 1'b0) begin bad++; $display("[TB] FAIL pulse_clears got=%0b exp=0", bpIf.mispredict); end
    total++; if (bpIf.redirect_pc !== 32'h104) begin bad++; $display("[TB] FAIL idle_redirect_hold got=%h exp=00000104", bpIf.redirect_pc); end
  endtask

  task automatic test_jump();
    do_update(32'h200, 3'b111, 1'b1, 32'h400, 1'b0, 32'h204);
    total++; if (bpIf.mispredict !== 1'b1) begin bad++; $display("[TB] FAIL jump_first_mispredict got=%0b exp=1", bpIf.mispredict); end
    total++; if (bpIf.redirect_pc !== 32'h400) begin bad++; $display("[TB] FAIL jump_redirect got=%h exp=00000400", bpIf.redirect_pc); end
    lookup(32'h200);
    total++; if (bpIf.pred_taken !== 1'b1 || bpIf.pred_target !== 32'h400) begin bad++; $display("[TB] FAIL jump_lookup got=%0b/%h exp=1/00000400", bpIf.pred_taken, bpIf.pred_target); end
    do_update(32'h200, 3'b111, 1'b1, 32'h400, 1'b1, 32'h400);
    total++; if (bpIf.mispredict !== 1'b0) begin bad++; $display("[TB] FAIL jump_repeat_mispredict got=%0b exp=0", bpIf.mispredict); end
  endtask

  task automatic test_alias();
    // 0x100 and 0x200 share index 0; entry currently holds the 0x200 jump
    do_update(32'h100, 3'b000, 1'b1, 32'h80, 1'b0, 32'h104);
    lookup(32'h100);
    total++; if (bpIf.pred_taken !== 1'b1 || bpIf.pred_target !== 32'h80) begin bad++; $display("[TB] FAIL alias_retrain got=%0b/%h exp=1/00000080", bpIf.pred_taken, bpIf.pred_target); end
    lookup(32'h200);
    total++; if (bpIf.pred_taken !== 1'b0 || bpIf.pred_target !== 32'h204) begin bad++; $display("[TB] FAIL alias_other_tag got=%0b/%h exp=0/00000204", bpIf.pred_taken, bpIf.pred_target); end
    do_update(32'h200, 3'b000, 1'b1, 32'h240, 1'b0, 32'h204);
    lookup(32'h200);
    total++; if (bpIf.pred_taken !== 1'b1 || bpIf.pred_target !== 32'h240) begin bad++; $display("[TB] FAIL alias_replace got=%0b/%h exp=1/00000240", bpIf.pred_taken, bpIf.pred_target); end
    lookup(32'h100);
    total++; if (bpIf.pred_taken !== 1'b0) begin bad++; $display("[TB] FAIL alias_evicted got=%0b exp=0", bpIf.pred_taken); end
    // replaced entry started at cnt=2, so one not-taken drops it to 1
    do_update(32'h200, 3'b010, 1'b0, 32'h240, 1'b1, 32'h240);
    lookup(32'h200);
    total++; if (bpIf.pred_taken !== 1'b0) begin bad++; $display("[TB] FAIL alias_cnt_was_2 got=%0b exp=0", bpIf.pred_taken); end
  endtask

  task automatic test_never_and_wrap();
    do_update(32'h180, 3'b110, 1'b0, 32'h0, 1'b0, 32'h184);
    total++; if (bpIf.mispredict !== 1'b0) begin bad++; $display("[TB] FAIL never_ok got=%0b exp=0", bpIf.mispredict); end
    do_update(32'h180, 3'b110, 1'b0, 32'h0, 1'b1, 32'h500);
    total++; if (bpIf.mispredict !== 1'b1 || bpIf.redirect_pc !== 32'h184) begin bad++; $display("[TB] FAIL never_mispredict got=%0b/%h exp=1/00000184", bpIf.mispredict, bpIf.redirect_pc); end
    lookup(32'h180);
    total++; if (bpIf.pred_taken !== 1'b0) begin bad++; $display("[TB] FAIL never_no_train got=%0b exp=0", bpIf.pred_taken); end
    lookup(32'hFFFF_FFFC);
    total++; if (bpIf.pred_target !== 32'h0) begin bad++; $display("[TB] FAIL wrap_target got=%h exp=00000000", bpIf.pred_target); end
  endtask

  task automatic test_same_cycle();
    bpIf.lk_pc = 32'h300;
    bpIf.upd_valid = 1'b1; bpIf.upd_pc = 32'h300; bpIf.upd_br_type = 3'b111;
    bpIf.upd_taken = 1'b1; bpIf.upd_target = 32'h500;
    bpIf.upd_pred_taken = 1'b0; bpIf.upd_pred_target = 32'h304;
    #1;
    total++; if (bpIf.pred_taken !== 1'b0 || bpIf.pred_target !== 32'h304) begin bad++; $display("[TB] FAIL same_cycle_old got=%0b/%h exp=0/00000304", bpIf.pred_taken, bpIf.pred_target); end
    @(posedge clk);
    #1;
    bpIf.upd_valid = 1'b0;
    #1;
    total++; if (bpIf.pred_taken !== 1'b1 || bpIf.pred_target !== 32'h500) begin bad++; $display("[TB] FAIL same_cycle_new got=%0b/%h exp=1/00000500", bpIf.pred_taken, bpIf.pred_target); end
  endtask

  task automatic test_reset_mid_update();
    do_update(32'h40, 3'b000, 1'b1, 32'h10, 1'b0, 32'h44);
    total++; if (bpIf.mispredict !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_mispredict got=%0b exp=1", bpIf.mispredict); end
    bpIf.upd_valid = 1'b1; bpIf.upd_pc = 32'h40; bpIf.upd_br_type = 3'b000;
    bpIf.upd_taken = 1'b1; bpIf.upd_target = 32'h20;
    bpIf.upd_pred_taken = 1'b0; bpIf.upd_pred_target = 32'h44;
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (bpIf.mispredict !== 1'b0 || bpIf.redirect_pc !== 32'h0) begin bad++; $display("[TB] FAIL async_reset got=%0b/%h exp=0/00000000", bpIf.mispredict, bpIf.redirect_pc); end
    @(posedge clk);
    #1;
    bpIf.upd_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bpIf.mispredict !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_mispredict got=%0b exp=0", bpIf.mispredict); end
    lookup(32'h40);
    total++; if (bpIf.pred_taken !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_40 got=%0b exp=0", bpIf.pred_taken); end
    lookup(32'h300);
    total++; if (bpIf.pred_taken !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_300 got=%0b exp=0", bpIf.pred_taken); end
    lookup(32'h200);
    total++; if (bpIf.pred_taken !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_200 got=%0b exp=0", bpIf.pred_taken); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_cond_train();
    test_jump();
    test_alias();
    test_never_and_wrap();
    test_same_cycle();
    test_reset_mid_update();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
